// File: rtl/pu_riscv_ahb3_mem_responder.sv
// AHB3-Lite memory slave: single-word-per-beat SRAM model with configurable wait
// states and a two-cycle ERROR response for out-of-range, oversized or misaligned beats.
module pu_riscv_ahb3_mem_responder #(
  parameter int XLEN        = 64,
  parameter int PLEN        = 64,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  // state | meaning
  // IDLE  | no wait pending; a completion cycle when pend_q is set
  // WAIT  | legal beat accepted, HREADYOUT low while cnt_q counts down
  // ERR1  | first ERROR cycle, HREADYOUT low
  // ERR2  | second ERROR cycle, HREADYOUT high, may accept a new beat

  localparam int NB    = XLEN / 8;
  localparam int BSB   = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int AW    = BSB + IDX_W;
  localparam logic [PLEN:0] MEM_BYTES = (PLEN+1)'(MEM_DEPTH * NB);
  localparam logic [3:0]    WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      size_q;
  logic            write_q;
  logic [XLEN-1:0] hrdata_q;
  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic            accept, illegal, addr_err, size_err, align_err;
  logic            rd_cmpl, wr_cmpl;
  logic [NB-1:0]   be;
  logic [BSB-1:0]  mask_q;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  function automatic logic [BSB-1:0] size_mask(input logic [2:0] s);
    logic [BSB-1:0] m;
    m = '0;
    for (int i = 0; i < BSB; i++) m[i] = (i < int'(s));
    return m;
  endfunction

  assign accept    = HSEL && HREADY && HTRANS[1] &&
                     (state_q == ST_IDLE || state_q == ST_ERR2);
  assign addr_err  = {1'b0, HADDR} >= MEM_BYTES;
  assign size_err  = HSIZE > 3'(BSB);
  assign align_err = |(HADDR[BSB-1:0] & size_mask(HSIZE));
  assign illegal   = addr_err || size_err || align_err;

  // FSM: state register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (illegal)              state_d = ST_ERR1;
          else if (WAIT_STATES > 0) state_d = ST_WAIT;
          else                      pend_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          pend_d  = 1'b1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
    HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2);
    rd_cmpl   = (state_q == ST_IDLE) && pend_q && !write_q;
    wr_cmpl   = (state_q == ST_IDLE) && pend_q && write_q;
    HRDATA    = rd_cmpl ? mem[addr_q[AW-1:BSB]] : hrdata_q;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      hrdata_q <= HRDATA;
      if (accept) begin
        addr_q  <= HADDR[AW-1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
      if (accept && !illegal)
        cnt_q <= WAIT_LOAD;
      else if (state_q == ST_WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  // Lanes sharing the aligned block of the captured address are enabled.
  assign mask_q = size_mask(size_q);
  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++)
      be[b] = (((BSB'(b)) ^ addr_q[BSB-1:0]) & ~mask_q) == '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn && wr_cmpl) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[addr_q[AW-1:BSB]][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end

endmodule
